mem_wb_stage: RTL and testbench

//  Consumer end of the EX-stage interface: accepts Instruction, Result, ZeroFlag and store data from EX.

---
 rtl/mem_wb_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_wb_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: takes EX results, runs LOAD/STORE over a req/ack memory port,
// drives the register-file write port, pulses BRZ branches and applies backpressure to EX.
module mem_wb_stage #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                  ClockInput,
  input  logic                  ResetInput,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [31:0]           Instruction,
  input  logic [DATA_WIDTH-1:0] Result,
  input  logic                  ZeroFlag,
  input  logic [DATA_WIDTH-1:0] StoreData,
  output logic                  MemReq,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemWData,
  input  logic                  MemAck,
  input  logic [DATA_WIDTH-1:0] MemRData,
  output logic                  RegWriteEnable,
  output logic [3:0]            RegWriteAddr,
  output logic [DATA_WIDTH-1:0] RegWriteData,
  output logic                  BranchTaken,
  output logic [DATA_WIDTH-1:0] BranchTarget,
  output logic                  MemError
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpLoad  = 4'h8;
  localparam logic [3:0] OpStore = 4'h9;
  localparam logic [3:0] OpBrz   = 4'hA;

  typedef enum logic [1:0] {StIdle, StMemReq, StWriteback} state_e;

  state_e                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [3:0]            dest_q, dest_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
  logic                  zero_q, zero_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [3:0]            waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  br_q, br_d;
  logic [DATA_WIDTH-1:0] btgt_q, btgt_d;
  logic                  err_q, err_d;

  logic       mem_req;
  logic [3:0] in_op;
  logic [3:0] in_dest;

  // Only opcode and destination fields are decoded here.
  logic unused_instr;
  assign unused_instr = ^{Instruction[23:0], zero_q};

  assign in_op   = Instruction[31:28];
  assign in_dest = Instruction[27:24];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dest_d  = dest_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    // Writeback outputs are single-cycle: cleared unless set by this transition.
    we_d    = 1'b0;
    waddr_d = 4'd0;
    wdata_d = '0;
    br_d    = 1'b0;
    btgt_d  = '0;

    unique case (state_q)
      StIdle, StWriteback: begin
        if (InValid) begin
          op_d    = in_op;
          dest_d  = in_dest;
          addr_d  = Result[ADDR_WIDTH-1:0];
          sdata_d = StoreData;
          zero_d  = ZeroFlag;
          if (in_op == OpLoad || in_op == OpStore) begin
            state_d = StMemReq;
            cnt_d   = '0;
          end else begin
            state_d = StWriteback;
            if (in_op == OpBrz) begin
              br_d   = ZeroFlag;
              btgt_d = Result;
            end else if (in_op != OpNop) begin
              we_d    = (in_dest != 4'd0);
              waddr_d = in_dest;
              wdata_d = Result;
            end
          end
        end else begin
          state_d = StIdle;
        end
      end
      StMemReq: begin
        // An ack in the expiry cycle takes priority over the timeout.
        if (MemAck) begin
          state_d = StWriteback;
          if (op_q == OpLoad) begin
            we_d    = (dest_q != 4'd0);
            waddr_d = dest_q;
            wdata_d = MemRData;
          end
        end else if (cnt_q == CntW'(MEM_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StWriteback;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ClockInput) begin
    if (ResetInput) begin
      state_q <= StIdle;
      op_q    <= 4'd0;
      dest_q  <= 4'd0;
      addr_q  <= '0;
      sdata_q <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= 4'd0;
      wdata_q <= '0;
      br_q    <= 1'b0;
      btgt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      br_q    <= br_d;
      btgt_q  <= btgt_d;
      err_q   <= err_d;
    end
  end

  assign mem_req        = (state_q == StMemReq);
  assign InReady        = (state_q == StIdle) || (state_q == StWriteback);
  assign MemReq         = mem_req;
  assign MemWrite       = mem_req && (op_q == OpStore);
  assign MemAddr        = mem_req ? addr_q : '0;
  assign MemWData       = (mem_req && (op_q == OpStore)) ? sdata_q : '0;
  assign RegWriteEnable = we_q;
  assign RegWriteAddr   = waddr_q;
  assign RegWriteData   = wdata_q;
  assign BranchTaken    = br_q;
  assign BranchTarget   = btgt_q;
  assign MemError       = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; register writes are checked against a scoreboard queue.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] result;
  logic        zero_flag;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        mem_error;

  always #5 clk = ~clk;

  mem_wb_stage #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (16),
    .MEM_TIMEOUT(16)
  ) dut (
    .ClockInput    (clk),
    .ResetInput    (rst),
    .InValid       (in_valid),
    .InReady       (in_ready),
    .Instruction   (instr),
    .Result        (result),
    .ZeroFlag      (zero_flag),
    .StoreData     (store_data),
    .MemReq        (mem_req),
    .MemWrite      (mem_write),
    .MemAddr       (mem_addr),
    .MemWData      (mem_wdata),
    .MemAck        (mem_ack),
    .MemRData      (mem_rdata),
    .RegWriteEnable(rf_we),
    .RegWriteAddr  (rf_waddr),
    .RegWriteData  (rf_wdata),
    .BranchTaken   (br_taken),
    .BranchTarget  (br_target),
    .MemError      (mem_error)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1 time unit after the edge, retire any register write.
  task automatic tick();
    wb_t e;
    @(posedge clk);
    #1;
    if (rf_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write", {63'd0, rf_we}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("wb_addr", {60'd0, rf_waddr}, {60'd0, e.addr});
        chk("wb_data", {32'd0, rf_wdata}, {32'd0, e.data});
      end
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] r,
                       input logic z, input logic [31:0] s);
    in_valid   = v;
    instr      = i;
    result     = r;
    zero_flag  = z;
    store_data = s;
  endtask

  task automatic push(input logic [3:0] a, input logic [31:0] d);
    wb_t e;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  initial begin
    int c;
    rst       = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    tick();
    tick();
    chk("rst_inready", {63'd0, in_ready}, 64'd1);
    chk("rst_memreq", {63'd0, mem_req}, 64'd0);
    chk("rst_we", {63'd0, rf_we}, 64'd0);
    chk("rst_br", {63'd0, br_taken}, 64'd0);
    chk("rst_err", {63'd0, mem_error}, 64'd0);
    rst = 1'b0;

    // ALU op to r5
    drive(1'b1, 32'h3500_0000, 32'h1234, 1'b0, 32'd0);
    push(4'd5, 32'h1234);
    tick();
    chk("alu_we", {63'd0, rf_we}, 64'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    tick();
    chk("alu_we_clear", {63'd0, rf_we}, 64'd0);

    // LOAD r2, ack in the third request cycle
    drive(1'b1, 32'h8200_0000, 32'h0040, 1'b0, 32'd0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("ld_memreq", {63'd0, mem_req}, 64'd1);
      chk("ld_inready", {63'd0, in_ready}, 64'd0);
      chk("ld_addr", {48'd0, mem_addr}, 64'h40);
      chk("ld_mwrite", {63'd0, mem_write}, 64'd0);
      if (k == 2) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        push(4'd2, 32'hDEAD_BEEF);
      end
      tick();
    end
    mem_ack = 1'b0;
    chk("ld_we", {63'd0, rf_we}, 64'd1);
    chk("ld_memreq_drop", {63'd0, mem_req}, 64'd0);
    tick();

    // STORE, immediate ack, no register write
    drive(1'b1, 32'h9300_0000, 32'h10, 1'b0, 32'hCAFE);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    chk("st_mwrite", {63'd0, mem_write}, 64'd1);
    chk("st_wdata", {32'd0, mem_wdata}, 64'hCAFE);
    chk("st_addr", {48'd0, mem_addr}, 64'h10);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("st_no_we", {63'd0, rf_we}, 64'd0);
    tick();

    // LOAD acked in the very last cycle before expiry: ack wins
    drive(1'b1, 32'h8900_0000, 32'h33, 1'b0, 32'd0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    for (int k = 0; k < 15; k++) tick();
    chk("edge_memreq", {63'd0, mem_req}, 64'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1357_9BDF;
    push(4'd9, 32'h1357_9BDF);
    tick();
    mem_ack = 1'b0;
    chk("edge_we", {63'd0, rf_we}, 64'd1);
    chk("edge_err", {63'd0, mem_error}, 64'd0);
    tick();

    // LOAD never acked: timeout after 16 request cycles
    drive(1'b1, 32'h8700_0000, 32'h55, 1'b0, 32'd0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    c = 0;
    while (mem_req === 1'b1 && c < 40) begin
      c++;
      tick();
    end
    chk("to_cycles", 64'(c), 64'd16);
    chk("to_err", {63'd0, mem_error}, 64'd1);
    chk("to_no_we", {63'd0, rf_we}, 64'd0);
    tick();
    tick();
    chk("to_err_sticky", {63'd0, mem_error}, 64'd1);

    // ALU op after the abort
    drive(1'b1, 32'h4600_0000, 32'h77, 1'b0, 32'd0);
    push(4'd6, 32'h77);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    chk("post_to_we", {63'd0, rf_we}, 64'd1);
    tick();

    // BRZ taken, BRZ not taken, ALU to r0
    drive(1'b1, 32'hA000_0000, 32'h200, 1'b1, 32'd0);
    tick();
    chk("brz_taken", {63'd0, br_taken}, 64'd1);
    chk("brz_target", {32'd0, br_target}, 64'h200);
    chk("brz_no_we", {63'd0, rf_we}, 64'd0);
    drive(1'b1, 32'hA000_0000, 32'h200, 1'b0, 32'd0);
    tick();
    chk("brz_not_taken", {63'd0, br_taken}, 64'd0);
    drive(1'b1, 32'h3000_0000, 32'h99, 1'b0, 32'd0);
    tick();
    chk("r0_no_we", {63'd0, rf_we}, 64'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    tick();
    chk("br_clear", {63'd0, br_taken}, 64'd0);

    // Four back-to-back ALU ops
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, {4'h1, 4'(k + 1), 24'd0}, 32'h100 + 32'(k), 1'b0, 32'd0);
      push(4'(k + 1), 32'h100 + 32'(k));
      tick();
      chk("b2b_we", {63'd0, rf_we}, 64'd1);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    tick();
    chk("b2b_end", {63'd0, rf_we}, 64'd0);

    // Reset in the middle of a LOAD, late ack ignored
    drive(1'b1, 32'h8100_0000, 32'h20, 1'b0, 32'd0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    tick();
    chk("mid_memreq", {63'd0, mem_req}, 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_memreq", {63'd0, mem_req}, 64'd0);
    chk("mid_rst_addr", {48'd0, mem_addr}, 64'd0);
    chk("mid_rst_we", {63'd0, rf_we}, 64'd0);
    chk("mid_rst_err", {63'd0, mem_error}, 64'd0);
    chk("mid_rst_inready", {63'd0, in_ready}, 64'd1);
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    tick();
    tick();
    mem_ack = 1'b0;
    chk("late_ack_we", {63'd0, rf_we}, 64'd0);
    chk("late_ack_memreq", {63'd0, mem_req}, 64'd0);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
